// File: rtl/cricket_pkg.sv
// Shared definitions for the cricket scorer: outcome codes, FSM states,
// innings limits and the run-value decode.
package cricket_pkg;

    localparam logic [3:0] DOT_MAX    = 4'd2;
    localparam logic [3:0] SINGLE_MAX = 4'd6;
    localparam logic [3:0] TWO_MAX    = 4'd9;
    localparam logic [3:0] THREE      = 4'd10;
    localparam logic [3:0] FOUR       = 4'd11;
    localparam logic [3:0] SIX        = 4'd12;
    localparam logic [3:0] WIDE       = 4'd13;
    localparam logic [3:0] NOBALL     = 4'd14;
    localparam logic [3:0] WICKET     = 4'd15;

    localparam int BALLS_PER_OVER = 6;
    localparam int MAX_WICKETS    = 10;

    typedef enum logic [1:0] {
        READY = 2'd0,
        SCORE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] run_value(input logic [3:0] code);
        logic [3:0] value;
        value = 4'd0;
        if (code <= DOT_MAX) begin
            value = 4'd0;
        end else if (code <= SINGLE_MAX) begin
            value = 4'd1;
        end else if (code <= TWO_MAX) begin
            value = 4'd2;
        end else begin
            case (code)
                THREE:        value = 4'd3;
                FOUR:         value = 4'd4;
                SIX:          value = 4'd6;
                WIDE, NOBALL: value = 4'd1;
                default:      value = 4'd0;
            endcase
        end
        return value;
    endfunction

    // Extras (wide, no-ball) are the only deliveries that do not count
    // towards the over.
    function automatic logic is_legal(input logic [3:0] code);
        return (code <= SIX) || (code == WICKET);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector. Stays disarmed for the first clock after
// reset so a level already high at release is not mistaken for an edge.
module rise_detect (
    input  logic clk_fpga,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = armed_q & sig_i & ~prev_q;

endmodule

// File: rtl/cricket_scorer.sv
// Cricket innings scorer: latches a random outcome code on each bowl request
// and applies it to runs/wickets/balls/overs on the following clock.
module cricket_scorer
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS = 5
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic       delivery,
    input  logic [3:0] outcome,
    input  logic       new_innings,
    output logic [8:0] runs,
    output logic [3:0] wickets,
    output logic [2:0] balls,
    output logic [3:0] overs,
    output logic [3:0] last_outcome,
    output logic       free_hit,
    output logic       ready,
    output logic       innings_done
);

    state_t     state_q, state_d;
    logic [8:0] runs_q, runs_d;
    logic [3:0] wickets_q, wickets_d;
    logic [2:0] balls_q, balls_d;
    logic [3:0] overs_q, overs_d;
    logic [3:0] last_q, last_d;
    logic       free_hit_q, free_hit_d;
    logic       delivery_rise;
    logic [9:0] runs_sum;

    rise_detect u_rise_detect (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .sig_i    (delivery),
        .rise_o   (delivery_rise)
    );

    assign runs_sum = {1'b0, runs_q} + {6'b0, run_value(last_q)};

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            state_q    <= READY;
            runs_q     <= 9'd0;
            wickets_q  <= 4'd0;
            balls_q    <= 3'd0;
            overs_q    <= 4'd0;
            last_q     <= 4'd0;
            free_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            runs_q     <= runs_d;
            wickets_q  <= wickets_d;
            balls_q    <= balls_d;
            overs_q    <= overs_d;
            last_q     <= last_d;
            free_hit_q <= free_hit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        runs_d     = runs_q;
        wickets_d  = wickets_q;
        balls_d    = balls_q;
        overs_d    = overs_q;
        last_d     = last_q;
        free_hit_d = free_hit_q;

        if (new_innings) begin
            state_d    = READY;
            runs_d     = 9'd0;
            wickets_d  = 4'd0;
            balls_d    = 3'd0;
            overs_d    = 4'd0;
            last_d     = 4'd0;
            free_hit_d = 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    if (delivery_rise) begin
                        last_d  = outcome;
                        state_d = SCORE;
                    end
                end
                SCORE: begin
                    runs_d = (runs_sum > 10'd511) ? 9'd511 : runs_sum[8:0];
                    // A wicket off a free hit is treated as a dot ball.
                    if (last_q == WICKET && !free_hit_q) begin
                        wickets_d = wickets_q + 4'd1;
                    end
                    if (is_legal(last_q)) begin
                        free_hit_d = 1'b0;
                        if (balls_q == 3'(BALLS_PER_OVER - 1)) begin
                            balls_d = 3'd0;
                            overs_d = overs_q + 4'd1;
                        end else begin
                            balls_d = balls_q + 3'd1;
                        end
                    end else if (last_q == NOBALL) begin
                        free_hit_d = 1'b1;
                    end
                    if (wickets_d == 4'(MAX_WICKETS) || overs_d == 4'(MAX_OVERS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = READY;
                end
            endcase
        end
    end

    assign runs         = runs_q;
    assign wickets      = wickets_q;
    assign balls        = balls_q;
    assign overs        = overs_q;
    assign last_outcome = last_q;
    assign free_hit     = free_hit_q;
    assign ready        = (state_q == READY);
    assign innings_done = (state_q == DONE);

endmodule

// File: tb/tb_cricket_scorer.sv
// Directed bench for cricket_scorer: a five-over instance and a one-over
// instance share the same stimulus; expected values are hand-computed.
module tb_cricket_scorer;

    logic       clk_fpga;
    logic       reset;
    logic       delivery;
    logic [3:0] outcome;
    logic       new_innings;

    logic [8:0] runs5, runs1;
    logic [3:0] wickets5, wickets1;
    logic [2:0] balls5, balls1;
    logic [3:0] overs5, overs1;
    logic [3:0] last5, last1;
    logic       free5, free1;
    logic       ready5, ready1;
    logic       done5, done1;

    int checks = 0;
    int passes = 0;

    cricket_scorer #(.MAX_OVERS(5)) dut5 (
        .clk_fpga     (clk_fpga),
        .reset        (reset),
        .delivery     (delivery),
        .outcome      (outcome),
        .new_innings  (new_innings),
        .runs         (runs5),
        .wickets      (wickets5),
        .balls        (balls5),
        .overs        (overs5),
        .last_outcome (last5),
        .free_hit     (free5),
        .ready        (ready5),
        .innings_done (done5)
    );

    cricket_scorer #(.MAX_OVERS(1)) dut1 (
        .clk_fpga     (clk_fpga),
        .reset        (reset),
        .delivery     (delivery),
        .outcome      (outcome),
        .new_innings  (new_innings),
        .runs         (runs1),
        .wickets      (wickets1),
        .balls        (balls1),
        .overs        (overs1),
        .last_outcome (last1),
        .free_hit     (free1),
        .ready        (ready1),
        .innings_done (done1)
    );

    initial clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One ball: rise at edge N latches the code, edge N+1 scores it. The live
    // outcome is scrambled before edge N+1 so only the latched code can count.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk_fpga);
        outcome  = code;
        delivery = 1'b1;
        @(negedge clk_fpga);
        delivery = 1'b0;
        outcome  = ~code;
        @(negedge clk_fpga);
    endtask

    task automatic startInnings();
        @(negedge clk_fpga);
        new_innings = 1'b1;
        @(negedge clk_fpga);
        new_innings = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        delivery    = 1'b0;
        outcome     = 4'd0;
        new_innings = 1'b0;
        repeat (3) @(negedge clk_fpga);

        checkOutput("reset_runs", runs5, 0);
        checkOutput("reset_wickets", wickets5, 0);
        checkOutput("reset_balls", balls5, 0);
        checkOutput("reset_overs", overs5, 0);
        checkOutput("reset_last", last5, 0);
        checkOutput("reset_free_hit", free5, 0);
        checkOutput("reset_ready", ready5, 1);
        checkOutput("reset_done", done5, 0);

        reset = 1'b1;
        repeat (2) @(negedge clk_fpga);

        // Four, with latency observed edge by edge.
        outcome  = 4'd11;
        delivery = 1'b1;
        @(negedge clk_fpga);
        checkOutput("four_latched", last5, 11);
        checkOutput("four_not_ready", ready5, 0);
        checkOutput("four_runs_edge1", runs5, 0);
        delivery = 1'b0;
        outcome  = 4'd0;
        @(negedge clk_fpga);
        checkOutput("four_runs_edge2", runs5, 4);
        checkOutput("four_balls", balls5, 1);
        checkOutput("four_ready", ready5, 1);

        applyStimulus(4'd12);
        checkOutput("six_runs", runs5, 10);
        applyStimulus(4'd3);
        checkOutput("single_runs", runs5, 11);
        checkOutput("single_balls", balls5, 3);
        checkOutput("single_overs", overs5, 0);
        checkOutput("single_last", last5, 3);

        // No-ball, then a wicket on the free hit, then a real wicket.
        startInnings();
        applyStimulus(4'd14);
        checkOutput("noball_runs", runs5, 1);
        checkOutput("noball_free_hit", free5, 1);
        checkOutput("noball_balls", balls5, 0);
        applyStimulus(4'd15);
        checkOutput("freehit_wickets", wickets5, 0);
        checkOutput("freehit_cleared", free5, 0);
        checkOutput("freehit_balls", balls5, 1);
        applyStimulus(4'd15);
        checkOutput("wicket_wickets", wickets5, 1);
        checkOutput("wicket_balls", balls5, 2);
        checkOutput("wicket_runs", runs5, 1);

        // Over rollover, then a wide.
        startInnings();
        for (int i = 0; i < 6; i++) applyStimulus(4'd0);
        checkOutput("over_overs", overs5, 1);
        checkOutput("over_balls", balls5, 0);
        checkOutput("max1_done", done1, 1);
        checkOutput("max1_overs", overs1, 1);
        applyStimulus(4'd13);
        checkOutput("wide_runs", runs5, 1);
        checkOutput("wide_balls", balls5, 0);
        checkOutput("wide_ready", ready5, 1);
        checkOutput("max1_wide_ignored", runs1, 0);
        checkOutput("max1_still_done", done1, 1);

        // All out.
        startInnings();
        for (int i = 0; i < 10; i++) applyStimulus(4'd15);
        checkOutput("allout_wickets", wickets5, 10);
        checkOutput("allout_done", done5, 1);
        checkOutput("allout_ready", ready5, 0);
        checkOutput("allout_overs", overs5, 1);
        checkOutput("allout_balls", balls5, 4);
        applyStimulus(4'd12);
        checkOutput("frozen_runs", runs5, 0);
        checkOutput("frozen_last", last5, 15);
        checkOutput("frozen_balls", balls5, 4);
        startInnings();
        checkOutput("clear_wickets", wickets5, 0);
        checkOutput("clear_overs", overs5, 0);
        checkOutput("clear_balls", balls5, 0);
        checkOutput("clear_last", last5, 0);
        checkOutput("clear_ready", ready5, 1);
        checkOutput("clear_done", done5, 0);

        // Held delivery level with a changing outcome scores one ball.
        @(negedge clk_fpga);
        outcome  = 4'd11;
        delivery = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_fpga);
            outcome = (i % 2 == 0) ? 4'd12 : 4'd15;
        end
        delivery = 1'b0;
        repeat (2) @(negedge clk_fpga);
        checkOutput("held_runs", runs5, 4);
        checkOutput("held_balls", balls5, 1);
        checkOutput("held_wickets", wickets5, 0);
        checkOutput("held_last", last5, 11);

        // Reset while a six is pending in SCORE.
        outcome  = 4'd12;
        delivery = 1'b1;
        @(posedge clk_fpga);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_runs", runs5, 0);
        checkOutput("midreset_balls", balls5, 0);
        checkOutput("midreset_last", last5, 0);
        checkOutput("midreset_ready", ready5, 1);
        @(negedge clk_fpga);
        reset = 1'b1;
        repeat (3) @(negedge clk_fpga);
        checkOutput("release_runs", runs5, 0);
        checkOutput("release_balls", balls5, 0);
        checkOutput("release_ready", ready5, 1);
        delivery = 1'b0;
        applyStimulus(4'd7);
        checkOutput("after_reset_runs", runs5, 2);
        checkOutput("after_reset_balls", balls5, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cricket_scorer.md
CRICKET_SCORER -- requirements
Module: cricket_scorer

Interface
REQ-001 Parameter MAX_OVERS, default 5, overs per innings (1..15).
REQ-002 Port clk_fpga  input  1  single system clock; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port delivery  input  1  bowl request level (button/level, synchronous to clk_fpga); one ball per rising edge of this level.
REQ-005 Port outcome  input  4  random outcome code from the 6-bit LFSR generator's q output.
REQ-006 Port new_innings  input  1  synchronous clear of the score, active-high.
REQ-007 Port runs  output  9  innings total, saturating.
REQ-008 Port wickets  output  4  wickets fallen, 0..10.
REQ-009 Port balls  output  3  legal balls in current over, 0..5.
REQ-010 Port overs  output  4  completed overs, 0..MAX_OVERS.
REQ-011 Port last_outcome  output  4  code of the most recently scored ball.
REQ-012 Port free_hit  output  1  next ball is a free hit.
REQ-013 Port ready  output  1  high in READY state only.
REQ-014 Port innings_done  output  1  high in DONE state only.

Function
REQ-015 Outcome decode: 0-2 dot (0 runs), 3-6 single, 7-9 two, 10 three, 11 four, 12 six, 13 wide, 14 no-ball, 15 wicket.
REQ-016 FSM states READY, SCORE, DONE; reset state READY.
REQ-017 Delivery detection: delivery=1 at edge N with delivery=0 at edge N-1 is a delivery event; a held level produces exactly one event.
REQ-018 READY + delivery event at edge N: outcome latched into last_outcome at edge N, state -> SCORE.
REQ-019 SCORE: counters updated at edge N+1 from the latched code, never from the live outcome; state -> DONE if termination condition met after update, else READY.
REQ-020 Delivery events in SCORE or DONE are discarded, not queued.
REQ-021 Run balls (codes 0-12): add runs, legal ball.
REQ-022 Wide (13): +1 run, not a legal ball, free_hit unchanged.
REQ-023 No-ball (14): +1 run, not a legal ball, free_hit set to 1.
REQ-024 Wicket (15): legal ball, 0 runs; wickets+1 unless free_hit=1, in which case no wicket (dot ball).
REQ-025 Any legal ball clears free_hit.
REQ-026 Legal ball: balls+1; at balls=5 wrap to 0 and overs+1.
REQ-027 runs saturates at 511; no wrap-around.
REQ-028 Termination: wickets=10, or overs=MAX_OVERS (balls=0).
REQ-029 DONE is held until new_innings; outputs frozen.
REQ-030 new_innings=1 at any edge, in any state: counters, free_hit and last_outcome to 0, state READY; takes priority over a simultaneous delivery event or SCORE update.

Reset
REQ-031 reset=0 asynchronously forces: runs=0, wickets=0, balls=0, overs=0, last_outcome=0, free_hit=0, state READY (ready=1, innings_done=0), edge-detect register=0.
REQ-032 Reset mid-SCORE discards the pending ball; no counter update after release.
REQ-033 A delivery level already high at reset release does not produce an event.

Structure
REQ-034 Shared package cricket_pkg holds: outcome code constants (DOT_MAX=2, SINGLE_MAX=6, TWO_MAX=9, THREE=10, FOUR=11, SIX=12, WIDE=13, NOBALL=14, WICKET=15), FSM state type, BALLS_PER_OVER=6, MAX_WICKETS=10.
REQ-035 One sub-module rise_detect (1-bit rising-edge detector, clk_fpga/active-low async reset) instantiated for delivery; decode and counters stay in cricket_scorer.

Verification
REQ-036 Reset, deliveries with outcomes 11,12,3 -> runs=11, balls=3, overs=0, last_outcome=3; each update exactly 2 edges after delivery rise.
REQ-037 Outcome 14 then 15 then 15 -> runs=1, free_hit=1 after no-ball, first wicket ignored (wickets=0), free_hit=0, second wicket counted (wickets=1), balls=2.
REQ-038 Six legal balls of code 0 then code 13 -> overs=1, balls=0, then runs=1, balls still 0; MAX_OVERS=1 -> innings_done=1 after sixth ball, wide ignored.
REQ-039 Ten code-15 deliveries -> wickets=10, innings_done=1, ready=0; further deliveries change nothing; new_innings -> all zero, ready=1.
REQ-040 delivery held high 20 cycles while outcome changes -> exactly one ball scored using code present at the rising edge; reset=0 asserted during SCORE -> all outputs 0 immediately, no later update.
